pre_if_stage: RTL and testbench
===============================

Name: pre_if_stage

Overview:
- Pre-IF stage. Generates the next fetch PC and issues it to the instruction SRAM over a req/addr_ok handshake.
- Hands each accepted PC to the IF stage.
- Redirects fetch on a WB exception (ex_entry), on ertn (ertn_pc) and on a taken branch from ID. A redirect that cannot be applied immediately is buffered.

Parameters:
- RESET_PC, 32'h1C000000, first fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- wb_ex  in  1  WB exception flush (same signal the CSR file consumes)
- ertn_flush  in  1  WB ertn flush
- ex_entry  in  32  exception entry address from the CSR file
- ertn_pc  in  32  exception return address from the CSR file
- br_taken  in  1  ID taken branch/jump, 1-cycle pulse
- br_target  in  32  branch target, valid with br_taken
- br_stall  in  1  ID branch not yet resolved; do not start a new request
- fs_allowin  in  1  IF can accept a PC
- inst_sram_req  out  1  fetch request
- inst_sram_addr  out  32  fetch address
- inst_sram_addr_ok  in  1  request accepted
- to_fs_valid  out  1  1-cycle pulse, PC handed to IF
- to_fs_pc  out  32  handed PC
- to_fs_adef  out  1  handed PC misaligned (IF/WB raise ADE/ADEF, BADV = pc)
- to_fs_discard  out  1  handed PC is stale; IF must drop the returned instruction

Behaviour:
- Reset (async):
  - state=RUN, seq_pc=RESET_PC-4, redirect buffer empty, stale=0.
  - All outputs 0.
- Redirect event: redir_now = wb_ex | ertn_flush | br_taken.
  - Priority: wb_ex > ertn_flush > br_taken.
  - Target is ex_entry / ertn_pc / br_target respectively.
- Redirect buffer {rb_valid, rb_kind, rb_target}: the event is written in its cycle, with these exceptions:
  - A branch never overwrites a buffered ex/ertn.
  - ex/ertn always overwrite.
  - ertn does not overwrite a buffered ex.
- next_pc = rb_valid ? rb_target : seq_pc+4, modulo 2^32 (wrap from FFFFFFFC to 0).
- States:
  - RUN
    - If redir_now | br_stall | !fs_allowin: req=0.
    - Else if next_pc[1:0]!=0: no SRAM request.
      - to_fs_valid=1, to_fs_pc=next_pc, to_fs_adef=1.
      - seq_pc<=next_pc, buffer cleared, go HALT.
    - Else: req=1, addr=next_pc.
      - If addr_ok: accept. Go to the accept actions below.
      - If !addr_ok: latch addr, go WAIT_ACK.
  - WAIT_ACK
    - req=1 and addr held stable, independent of fs_allowin, br_stall and redirects.
    - A redirect arriving here is buffered and sets stale=1.
    - On addr_ok: accept. Then go RUN and clear stale.
  - HALT
    - req=0, no handoff.
    - Leave to RUN only on a redirect event. The buffered target becomes next_pc; the earliest fetch is the cycle after the event.
- Accept (same cycle as addr_ok):
  - to_fs_valid=1, to_fs_pc=addr, to_fs_adef=0.
  - to_fs_discard = stale | redir_now.
  - seq_pc<=addr.
  - If the buffer was the source of addr and no new event arrived this cycle, clear it.
- Latency:
  - Redirect to first request with the new target: exactly 1 cycle if RUN, fs_allowin=1 and br_stall=0.
  - An accepted request produces to_fs_valid in the same cycle.
- to_fs_pc, to_fs_adef and to_fs_discard are 0 whenever to_fs_valid=0.
- Reset asserted mid-WAIT_ACK aborts immediately: req drops asynchronously and the buffer is cleared.

Test Plan:
- Reset release, fs_allowin=1, addr_ok=1 -> addresses 1C000000, 1C000004, 1C000008 on consecutive cycles; to_fs_discard=0.
- wb_ex=1 with ex_entry=1C008000 in RUN -> req=0 that cycle; next cycle addr=1C008000; then 1C008004.
- Hold addr_ok=0 for 3 cycles at 1C000010; br_taken=1, br_target=1C000100 in the 2nd cycle -> addr stays 1C000010; on accept to_fs_discard=1; next request 1C000100.
- Same cycle wb_ex (ex_entry=1C008000) + br_taken (1C000200) -> 1C008000 fetched. Buffered ex followed by a branch pulse -> branch ignored.
- ertn_flush with ertn_pc=1C000402 -> next cycle to_fs_valid=1, to_fs_adef=1, pc=1C000402, req=0. Stays halted until wb_ex with ex_entry=1C008000 -> fetch 1C008000.
- br_stall=1 for 2 cycles, then fs_allowin=0 -> no requests. Release both -> fetch resumes at seq_pc+4 with no PC skipped.

Source files
------------

// File: rtl/pre_if_stage.sv
// rtl/pre_if_stage.sv - Pre-IF stage: next-PC generation, inst SRAM request issue and redirect buffering
// Redirects arriving while a request is outstanding mark the in-flight fetch stale and are replayed afterwards.
module pre_if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1C000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_ex,
  input  logic        ertn_flush,
  input  logic [31:0] ex_entry,
  input  logic [31:0] ertn_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        br_stall,
  input  logic        fs_allowin,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  output logic        to_fs_valid,
  output logic [31:0] to_fs_pc,
  output logic        to_fs_adef,
  output logic        to_fs_discard
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [1:0] K_BR   = 2'd0;
  localparam logic [1:0] K_ERTN = 2'd1;
  localparam logic [1:0] K_EX   = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_seq_pc;
  logic        r_rb_valid;
  logic [1:0]  r_rb_kind;
  logic [31:0] r_rb_target;
  logic        r_stale;
  logic [31:0] r_addr;
  logic        r_from_rb;

  logic        w_redir_now;
  logic [1:0]  w_ev_kind;
  logic [31:0] w_ev_target;
  logic        w_rb_write;
  logic [31:0] w_next_pc;
  logic        w_run_go;
  logic        w_misal;
  logic        w_adef_hand;
  logic        w_req;
  logic [31:0] w_req_addr;
  logic        w_accept;
  logic        w_src_rb;
  logic        w_rb_clear;

  assign w_redir_now = wb_ex | ertn_flush | br_taken;

  always_comb begin
    w_ev_kind   = K_BR;
    w_ev_target = br_target;
    if (wb_ex) begin
      w_ev_kind   = K_EX;
      w_ev_target = ex_entry;
    end else if (ertn_flush) begin
      w_ev_kind   = K_ERTN;
      w_ev_target = ertn_pc;
    end
  end

  // A lower-priority event never displaces a buffered higher-priority one.
  always_comb begin
    w_rb_write = 1'b0;
    if (wb_ex)
      w_rb_write = 1'b1;
    else if (ertn_flush)
      w_rb_write = !(r_rb_valid && (r_rb_kind == K_EX));
    else if (br_taken)
      w_rb_write = !(r_rb_valid && (r_rb_kind != K_BR));
  end

  assign w_next_pc   = r_rb_valid ? r_rb_target : (r_seq_pc + 32'd4);
  assign w_run_go    = (r_state == S_RUN) && !w_redir_now && !br_stall && fs_allowin;
  assign w_misal     = |w_next_pc[1:0];
  assign w_adef_hand = !rst && w_run_go && w_misal;
  assign w_req       = !rst && ((w_run_go && !w_misal) || (r_state == S_WAIT));
  assign w_req_addr  = (r_state == S_WAIT) ? r_addr : w_next_pc;
  assign w_accept    = w_req && inst_sram_addr_ok;

  // In WAIT the buffer only counts as the source if no redirect has touched it since issue.
  assign w_src_rb    = (r_state == S_WAIT) ? r_from_rb : r_rb_valid;
  assign w_rb_clear  = (w_accept && w_src_rb && !w_redir_now) || w_adef_hand;

  assign inst_sram_req  = w_req;
  assign inst_sram_addr = w_req ? w_req_addr : 32'd0;
  assign to_fs_valid    = w_accept || w_adef_hand;
  assign to_fs_pc       = w_accept ? w_req_addr : (w_adef_hand ? w_next_pc : 32'd0);
  assign to_fs_adef     = w_adef_hand;
  assign to_fs_discard  = w_accept && (r_stale || w_redir_now);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rb_valid  <= 1'b0;
      r_rb_kind   <= K_BR;
      r_rb_target <= 32'd0;
    end else if (w_rb_write) begin
      r_rb_valid  <= 1'b1;
      r_rb_kind   <= w_ev_kind;
      r_rb_target <= w_ev_target;
    end else if (w_rb_clear) begin
      r_rb_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RUN;
      r_seq_pc  <= RESET_PC - 32'd4;
      r_stale   <= 1'b0;
      r_addr    <= 32'd0;
      r_from_rb <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_adef_hand) begin
            r_seq_pc <= w_next_pc;
            r_state  <= S_HALT;
          end else if (w_req) begin
            if (inst_sram_addr_ok) begin
              r_seq_pc <= w_next_pc;
            end else begin
              r_addr    <= w_next_pc;
              r_from_rb <= r_rb_valid;
              r_state   <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (w_redir_now) begin
            r_stale   <= 1'b1;
            r_from_rb <= 1'b0;
          end
          if (inst_sram_addr_ok) begin
            r_seq_pc <= r_addr;
            r_stale  <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_HALT: begin
          if (w_redir_now)
            r_state <= S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pre_if_stage.sv
// tb/tb_pre_if_stage.sv - Scoreboard testbench for pre_if_stage
// Each table row drives one cycle; expected handoffs are queued on drive and popped when to_fs_valid fires.
module tb_pre_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wb_ex = 1'b0;
  logic        ertn_flush = 1'b0;
  logic [31:0] ex_entry = 32'h1C008000;
  logic [31:0] ertn_pc = 32'h1C000402;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        br_stall = 1'b0;
  logic        fs_allowin = 1'b1;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok = 1'b1;
  logic        to_fs_valid;
  logic [31:0] to_fs_pc;
  logic        to_fs_adef;
  logic        to_fs_discard;

  pre_if_stage #(.RESET_PC(32'h1C000000)) dut (
    .clk(clk), .rst(rst), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .ex_entry(ex_entry), .ertn_pc(ertn_pc), .br_taken(br_taken),
    .br_target(br_target), .br_stall(br_stall), .fs_allowin(fs_allowin),
    .inst_sram_req(inst_sram_req), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .to_fs_valid(to_fs_valid),
    .to_fs_pc(to_fs_pc), .to_fs_adef(to_fs_adef), .to_fs_discard(to_fs_discard)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wb, er, br, st, al, ok;
    logic [31:0] tgt;
    bit          req;
    logic [31:0] addr;
    bit          hv, adef, disc;
  } row_t;

  typedef struct {
    logic [31:0] pc;
    bit          adef, disc;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic row_t R(bit wb, bit er, bit br, bit st, bit al, bit ok, logic [31:0] tgt,
                             bit req, logic [31:0] addr, bit hv, bit adef, bit disc);
    row_t r;
    r.wb = wb; r.er = er; r.br = br; r.st = st; r.al = al; r.ok = ok; r.tgt = tgt;
    r.req = req; r.addr = addr; r.hv = hv; r.adef = adef; r.disc = disc;
    return r;
  endfunction

  // Drives inputs for one cycle and queues the handoff that cycle should produce.
  task automatic drive(input row_t r);
    exp_t e;
    wb_ex = r.wb; ertn_flush = r.er; br_taken = r.br; br_target = r.tgt;
    br_stall = r.st; fs_allowin = r.al; inst_sram_addr_ok = r.ok;
    if (r.hv) begin
      e.pc = r.addr; e.adef = r.adef; e.disc = r.disc;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset;
    drive(R(0,0,0,0,1,1,32'd0, 0,32'd0,0,0,0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({inst_sram_req, inst_sram_addr, to_fs_valid, to_fs_pc, to_fs_adef, to_fs_discard} !== 67'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: req=%b addr=%h valid=%b pc=%h adef=%b disc=%b, want all 0",
               inst_sram_req, inst_sram_addr, to_fs_valid, to_fs_pc, to_fs_adef, to_fs_discard);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_sequential;
    row_t t[$];
    exp_t e;
    t.push_back(R(0,0,0,0,1,1,32'd0, 1,32'h1C000000,1,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0, 1,32'h1C000004,1,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0, 1,32'h1C000008,1,0,0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      n_cmp++;
      if (inst_sram_req !== t[i].req || (t[i].req && inst_sram_addr !== t[i].addr) || to_fs_valid !== t[i].hv) begin
        n_bad++;
        $display("FAIL seq[%0d]: req=%b addr=%h valid=%b, want req=%b addr=%h valid=%b",
                 i, inst_sram_req, inst_sram_addr, to_fs_valid, t[i].req, t[i].addr, t[i].hv);
      end
      n_cmp++;
      if (to_fs_valid) begin
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL seq[%0d] handoff: got pc=%h, want no handoff", i, to_fs_pc);
        end else begin
          e = sb.pop_front();
          if (to_fs_pc !== e.pc || to_fs_adef !== e.adef || to_fs_discard !== e.disc) begin
            n_bad++;
            $display("FAIL seq[%0d] handoff: got pc=%h adef=%b disc=%b, want pc=%h adef=%b disc=%b",
                     i, to_fs_pc, to_fs_adef, to_fs_discard, e.pc, e.adef, e.disc);
          end
        end
      end else if ({to_fs_pc, to_fs_adef, to_fs_discard} !== 34'd0) begin
        n_bad++; $display("FAIL seq[%0d] idle_zero: got pc=%h adef=%b disc=%b, want 0", i, to_fs_pc, to_fs_adef, to_fs_discard);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL seq drain: %0d handoffs missing, want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_exception;
    row_t t[$];
    exp_t e;
    t.push_back(R(1,0,0,0,1,1,32'd0, 0,32'd0,0,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0, 1,32'h1C008000,1,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0, 1,32'h1C008004,1,0,0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      n_cmp++;
      if (inst_sram_req !== t[i].req || (t[i].req && inst_sram_addr !== t[i].addr) || to_fs_valid !== t[i].hv) begin
        n_bad++;
        $display("FAIL ex[%0d]: req=%b addr=%h valid=%b, want req=%b addr=%h valid=%b",
                 i, inst_sram_req, inst_sram_addr, to_fs_valid, t[i].req, t[i].addr, t[i].hv);
      end
      if (to_fs_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL ex[%0d] handoff: got pc=%h, want no handoff", i, to_fs_pc);
        end else begin
          e = sb.pop_front();
          if (to_fs_pc !== e.pc || to_fs_adef !== e.adef || to_fs_discard !== e.disc) begin
            n_bad++;
            $display("FAIL ex[%0d] handoff: got pc=%h adef=%b disc=%b, want pc=%h adef=%b disc=%b",
                     i, to_fs_pc, to_fs_adef, to_fs_discard, e.pc, e.adef, e.disc);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL ex drain: %0d handoffs missing, want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_wait_ack_branch;
    row_t t[$];
    exp_t e;
    t.push_back(R(0,0,1,0,1,1,32'h1C000010, 0,32'd0,0,0,0));
    t.push_back(R(0,0,0,0,1,0,32'd0,        1,32'h1C000010,0,0,0));
    t.push_back(R(0,0,1,0,1,0,32'h1C000100, 1,32'h1C000010,0,0,0));
    t.push_back(R(0,0,0,1,0,0,32'd0,        1,32'h1C000010,0,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0,        1,32'h1C000010,1,0,1));
    t.push_back(R(0,0,0,0,1,1,32'd0,        1,32'h1C000100,1,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0,        1,32'h1C000104,1,0,0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      n_cmp++;
      if (inst_sram_req !== t[i].req || (t[i].req && inst_sram_addr !== t[i].addr) || to_fs_valid !== t[i].hv) begin
        n_bad++;
        $display("FAIL wait[%0d]: req=%b addr=%h valid=%b, want req=%b addr=%h valid=%b",
                 i, inst_sram_req, inst_sram_addr, to_fs_valid, t[i].req, t[i].addr, t[i].hv);
      end
      if (to_fs_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL wait[%0d] handoff: got pc=%h, want no handoff", i, to_fs_pc);
        end else begin
          e = sb.pop_front();
          if (to_fs_pc !== e.pc || to_fs_adef !== e.adef || to_fs_discard !== e.disc) begin
            n_bad++;
            $display("FAIL wait[%0d] handoff: got pc=%h adef=%b disc=%b, want pc=%h adef=%b disc=%b",
                     i, to_fs_pc, to_fs_adef, to_fs_discard, e.pc, e.adef, e.disc);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL wait drain: %0d handoffs missing, want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_priority;
    row_t t[$];
    exp_t e;
    t.push_back(R(1,0,1,0,1,1,32'h1C000200, 0,32'd0,0,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0,        1,32'h1C008000,1,0,0));
    t.push_back(R(1,0,0,0,0,1,32'd0,        0,32'd0,0,0,0));
    t.push_back(R(0,0,1,0,1,1,32'h1C000200, 0,32'd0,0,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0,        1,32'h1C008000,1,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0,        1,32'h1C008004,1,0,0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      n_cmp++;
      if (inst_sram_req !== t[i].req || (t[i].req && inst_sram_addr !== t[i].addr) || to_fs_valid !== t[i].hv) begin
        n_bad++;
        $display("FAIL prio[%0d]: req=%b addr=%h valid=%b, want req=%b addr=%h valid=%b",
                 i, inst_sram_req, inst_sram_addr, to_fs_valid, t[i].req, t[i].addr, t[i].hv);
      end
      if (to_fs_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL prio[%0d] handoff: got pc=%h, want no handoff", i, to_fs_pc);
        end else begin
          e = sb.pop_front();
          if (to_fs_pc !== e.pc || to_fs_adef !== e.adef || to_fs_discard !== e.disc) begin
            n_bad++;
            $display("FAIL prio[%0d] handoff: got pc=%h adef=%b disc=%b, want pc=%h adef=%b disc=%b",
                     i, to_fs_pc, to_fs_adef, to_fs_discard, e.pc, e.adef, e.disc);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL prio drain: %0d handoffs missing, want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_ertn_halt;
    row_t t[$];
    exp_t e;
    t.push_back(R(0,1,0,0,1,1,32'd0, 0,32'd0,0,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0, 0,32'h1C000402,1,1,0));
    t.push_back(R(0,0,0,0,1,1,32'd0, 0,32'd0,0,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0, 0,32'd0,0,0,0));
    t.push_back(R(1,0,0,0,1,1,32'd0, 0,32'd0,0,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0, 1,32'h1C008000,1,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0, 1,32'h1C008004,1,0,0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      n_cmp++;
      if (inst_sram_req !== t[i].req || (t[i].req && inst_sram_addr !== t[i].addr) || to_fs_valid !== t[i].hv) begin
        n_bad++;
        $display("FAIL ertn[%0d]: req=%b addr=%h valid=%b, want req=%b addr=%h valid=%b",
                 i, inst_sram_req, inst_sram_addr, to_fs_valid, t[i].req, t[i].addr, t[i].hv);
      end
      n_cmp++;
      if (to_fs_valid) begin
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL ertn[%0d] handoff: got pc=%h, want no handoff", i, to_fs_pc);
        end else begin
          e = sb.pop_front();
          if (to_fs_pc !== e.pc || to_fs_adef !== e.adef || to_fs_discard !== e.disc) begin
            n_bad++;
            $display("FAIL ertn[%0d] handoff: got pc=%h adef=%b disc=%b, want pc=%h adef=%b disc=%b",
                     i, to_fs_pc, to_fs_adef, to_fs_discard, e.pc, e.adef, e.disc);
          end
        end
      end else if ({to_fs_pc, to_fs_adef, to_fs_discard} !== 34'd0) begin
        n_bad++; $display("FAIL ertn[%0d] idle_zero: got pc=%h adef=%b disc=%b, want 0", i, to_fs_pc, to_fs_adef, to_fs_discard);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL ertn drain: %0d handoffs missing, want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_stall_wrap;
    row_t t[$];
    exp_t e;
    t.push_back(R(0,0,0,1,1,1,32'd0,        0,32'd0,0,0,0));
    t.push_back(R(0,0,0,1,1,1,32'd0,        0,32'd0,0,0,0));
    t.push_back(R(0,0,0,0,0,1,32'd0,        0,32'd0,0,0,0));
    t.push_back(R(0,0,0,0,0,1,32'd0,        0,32'd0,0,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0,        1,32'h1C008008,1,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0,        1,32'h1C00800C,1,0,0));
    t.push_back(R(0,0,1,0,1,1,32'hFFFFFFFC, 0,32'd0,0,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0,        1,32'hFFFFFFFC,1,0,0));
    t.push_back(R(0,0,0,0,1,1,32'd0,        1,32'h00000000,1,0,0));
    foreach (t[i]) begin
      drive(t[i]);
      @(negedge clk);
      n_cmp++;
      if (inst_sram_req !== t[i].req || (t[i].req && inst_sram_addr !== t[i].addr) || to_fs_valid !== t[i].hv) begin
        n_bad++;
        $display("FAIL stall[%0d]: req=%b addr=%h valid=%b, want req=%b addr=%h valid=%b",
                 i, inst_sram_req, inst_sram_addr, to_fs_valid, t[i].req, t[i].addr, t[i].hv);
      end
      if (to_fs_valid) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++; $display("FAIL stall[%0d] handoff: got pc=%h, want no handoff", i, to_fs_pc);
        end else begin
          e = sb.pop_front();
          if (to_fs_pc !== e.pc || to_fs_adef !== e.adef || to_fs_discard !== e.disc) begin
            n_bad++;
            $display("FAIL stall[%0d] handoff: got pc=%h adef=%b disc=%b, want pc=%h adef=%b disc=%b",
                     i, to_fs_pc, to_fs_adef, to_fs_discard, e.pc, e.adef, e.disc);
          end
        end
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL stall drain: %0d handoffs missing, want 0", sb.size()); sb.delete();
    end
  endtask

  task automatic test_reset_mid_wait;
    drive(R(0,0,0,0,1,0,32'd0, 0,32'd0,0,0,0));
    @(negedge clk);
    n_cmp++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h00000004) begin
      n_bad++; $display("FAIL rstwait issue: req=%b addr=%h, want req=1 addr=00000004", inst_sram_req, inst_sram_addr);
    end
    @(posedge clk); #1;
    drive(R(0,0,1,0,1,0,32'h1C000300, 0,32'd0,0,0,0));
    @(posedge clk); #1;
    drive(R(0,0,0,0,1,0,32'd0, 0,32'd0,0,0,0));
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (inst_sram_req !== 1'b0 || inst_sram_addr !== 32'd0 || to_fs_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstwait abort: req=%b addr=%h valid=%b, want 0", inst_sram_req, inst_sram_addr, to_fs_valid);
    end
    @(posedge clk); #1;
    drive(R(0,0,0,0,1,1,32'd0, 0,32'd0,0,0,0));
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (inst_sram_req !== 1'b1 || inst_sram_addr !== 32'h1C000000 || to_fs_valid !== 1'b1 ||
        to_fs_pc !== 32'h1C000000 || to_fs_discard !== 1'b0) begin
      n_bad++;
      $display("FAIL rstwait restart: req=%b addr=%h valid=%b pc=%h disc=%b, want 1 1C000000 1 1C000000 0",
               inst_sram_req, inst_sram_addr, to_fs_valid, to_fs_pc, to_fs_discard);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within bound");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_sequential();
    test_exception();
    test_wait_ack_branch();
    test_priority();
    test_ertn_halt();
    test_stall_wrap();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
